// File: rtl/r_multicycle_ctrl.sv
// rtl/r_multicycle_ctrl.sv - multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer for RV32I R-type
module r_multicycle_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        ab_load,
  output logic [3:0]  alu_ctrl,
  output logic        res_load,
  output logic        reg_write,
  output logic        pc_en,
  output logic        illegal,
  output logic        busy,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_TRAP
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] instret_q, instret_d;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic        legal;
  logic [3:0]  alu_dec;

  assign funct7 = ir_q[31:25];
  assign funct3 = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign rd     = ir_q[11:7];

  // funct7 = 0100000 only selects the alternate SUB/SRA forms
  assign legal = (ir_q[6:0] == 7'b0110011) &&
                 ((funct7 == 7'b0000000) ||
                  ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101))));

  always_comb begin
    alu_dec = 4'b0000;
    case (funct3)
      3'b000:  alu_dec = funct7[5] ? 4'b0001 : 4'b0000;
      3'b001:  alu_dec = 4'b0010;
      3'b010:  alu_dec = 4'b0011;
      3'b011:  alu_dec = 4'b0100;
      3'b100:  alu_dec = 4'b0101;
      3'b101:  alu_dec = funct7[5] ? 4'b0111 : 4'b0110;
      3'b110:  alu_dec = 4'b1000;
      default: alu_dec = 4'b1001;
    endcase
  end

  // IR only changes on a fetch, so the decoded op stays stable until the next one
  assign alu_ctrl = alu_dec;

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    instret_d = instret_q;
    imem_req  = 1'b0;
    ab_load   = 1'b0;
    res_load  = 1'b0;
    reg_write = 1'b0;
    pc_en     = 1'b0;
    illegal   = 1'b0;
    busy      = 1'b1;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (legal) begin
          ab_load = 1'b1;
          state_d = S_EXECUTE;
        end else begin
          state_d = S_TRAP;
        end
      end
      S_EXECUTE: begin
        res_load = 1'b1;
        state_d  = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        reg_write = (rd != 5'd0);
        pc_en     = 1'b1;
        instret_d = instret_q + 32'd1;
        state_d   = run ? S_FETCH : S_IDLE;
      end
      S_TRAP: begin
        illegal = 1'b1;
        busy    = 1'b0;
      end
      default: begin
        busy    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ir_q      <= 32'd0;
      instret_q <= 32'd0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      if (instret_d != instret_q) instret_q <= instret_d;
    end
  end

  assign instret = instret_q;

endmodule

// File: doc/r_multicycle_ctrl.md
# r_multicycle_ctrl

Multi-cycle sequencer for the R-type datapath (instruction fetch unit, register file, R-type ALU). It fetches one instruction at a time over a req/ack handshake to instruction memory and holds it in an internal instruction register. It decodes each instruction and walks it through DECODE, EXECUTE and WRITEBACK, emitting the load/enable strobes and ALU control for each step. It replaces the single-cycle combinational control path, traps on illegal encodings and counts retired instructions.

## Interface
- No parameters. All widths are fixed by RV32I.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- run  input  1  level-sensitive. 1 = keep executing; 0 = stop at the next instruction boundary.
- imem_req  output  1  fetch request. High throughout FETCH.
- imem_ack  input  1  instruction valid on imem_rdata. Sampled only in FETCH.
- imem_rdata  input  32  fetched instruction word.
- rs1, rs2, rd  output  5 each  register indices: rs1 = IR[19:15], rs2 = IR[24:20], rd = IR[11:7].
- ab_load  output  1  pulse: latch register file read data into operand registers A/B.
- alu_ctrl  output  4  ALU operation. Held from DECODE until the next FETCH.
- res_load  output  1  pulse: latch ALU result.
- reg_write  output  1  pulse: register file write enable.
- pc_en  output  1  pulse: advance PC by 4.
- illegal  output  1  sticky trap flag.
- busy  output  1  high in every state except IDLE and TRAP.
- instret  output  32  retired-instruction counter.

## Operation
- Reset is asynchronous: the FSM goes to IDLE, IR = 0, instret = 0, alu_ctrl = 0, and every strobe, imem_req, illegal and busy are 0.
- States and transitions:
  - IDLE → FETCH when run = 1.
  - FETCH: imem_req = 1. On a clock edge with imem_ack = 1, IR <= imem_rdata and the FSM moves to DECODE. Otherwise it stays in FETCH with no timeout.
  - DECODE: checks legality. Illegal → TRAP. Legal → ab_load = 1, alu_ctrl set, next state EXECUTE.
  - EXECUTE: res_load = 1. Next state WRITEBACK.
  - WRITEBACK: reg_write = (rd != 0), pc_en = 1, instret += 1. Next state FETCH if run = 1, otherwise IDLE.
  - TRAP: illegal = 1. No strobes. Only rst exits this state.
- Legality rules:
  - IR[6:0] must equal 0110011.
  - funct7 (IR[31:25]) must be 0000000 or 0100000.
  - funct7 = 0100000 is legal only with funct3 = 000 (SUB) or 101 (SRA).
- alu_ctrl encoding (funct7 bit 5 together with funct3):
  - ADD 0000, SUB 0001, SLL 0010, SLT 0011, SLTU 0100.
  - XOR 0101, SRL 0110, SRA 0111, OR 1000, AND 1001.
- Writes to x0 are suppressed: reg_write stays 0 when rd = 0. pc_en and the instret increment still occur.
- instret wraps from 0xFFFFFFFF to 0 with no flag.
- imem_ack outside FETCH is ignored, and IR is unchanged.
- run is sampled only in IDLE and WRITEBACK. Dropping run mid-instruction does not abort that instruction.

## Timing
- All strobes are Moore outputs, high for exactly one cycle in their state.
- Per-instruction latency is 4 cycles plus N, where N is the number of extra FETCH cycles spent waiting for imem_ack. With ack in the first FETCH cycle, N = 0 and one instruction retires every 4 cycles.
- Ordering within one instruction:
  - ab_load is 1 cycle after the IR load.
  - res_load is 1 cycle after ab_load.
  - reg_write and pc_en share the cycle after res_load.
  - instret shows the new value from the following edge.
- From IDLE with run = 1, imem_req rises 1 cycle later.
- An illegal instruction raises illegal 1 cycle after its DECODE cycle. No reg_write, pc_en or instret change occurs for it.
- rst asserted in any state forces IDLE immediately, without waiting for a clock edge. A pending fetch is dropped and imem_req falls at once.

## Test plan
- **Legal ADD, ack in first FETCH cycle:** run = 1, imem_rdata = 0x002081B3 (add x3,x1,x2) → rs1 = 1, rs2 = 2, rd = 3, alu_ctrl = 0000. Strobes fire in order ab_load, res_load, then reg_write + pc_en. instret = 1 after 4 cycles.
- **Back-to-back SUB and SRA:** 0x40208233 then 0x4020D2B3 → alu_ctrl = 0001 then 0111. instret = 2 after 8 cycles.
- **Delayed ack and write to x0:** ack held low for 3 FETCH cycles, instruction 0x00208033 (rd = x0) → latency 7 cycles, reg_write never asserts, pc_en pulses once, instret = 1.
- **Illegal encodings:** 0x00000013 (ADDI) and, after a fresh reset, 0x4020C1B3 (funct7 = 0100000 with funct3 = 100) → each ends in TRAP with illegal = 1, instret = 0, no reg_write, no pc_en. The FSM stays in TRAP for 20 cycles, then rst clears it.
- **run dropped mid-instruction:** run falls during EXECUTE → that instruction retires (instret + 1), the FSM enters IDLE, imem_req stays 0. Raising run restarts FETCH 1 cycle later.
- **Asynchronous reset and instret wrap:**
  - rst pulsed between clock edges during FETCH → all outputs read 0 before the next edge.
  - instret forced to 0xFFFFFFFF, then one retire → instret = 0x00000000.
